// File: rtl/fetch_controller.sv
// Instruction fetch controller: one outstanding imem request feeding a single IF/ID entry.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | first cycle after reset, no request yet
// REQ   | presenting imem_req at pc, waiting for a grant
// WAIT  | request granted, waiting for its response
// DROP  | redirected while waiting, next response is discarded
module fetch_controller #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            flush_valid,
  input  logic [XLEN-1:0] flush_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic            load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (!flush_valid && imem_req && imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)      state_d = S_REQ;
        else if (flush_valid) state_d = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid && !flush_valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The entry slot is free if empty or being consumed on this edge.
  always_comb begin
    imem_req = (state_q == S_REQ) && !flush_valid && (!if_valid_q || !stall);
  end

  assign load = (state_q == S_WAIT) && imem_rvalid && !flush_valid;

  always_comb begin
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if (flush_valid) begin
      if_valid_d = 1'b0;
      pc_d       = flush_pc & ~XLEN'(3);
    end else if (load) begin
      if_valid_d = 1'b1;
      if_pc_d    = pc_q;
      if_instr_d = imem_rdata;
      pc_d       = pc_q + XLEN'(4);
    end else if (if_valid_q && !stall) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = load ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
    flush_cnt_d = flush_valid ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus randomized traffic against a
// transaction-level model (fetch slot / outstanding request / pending discard).
module tb_fetch_controller;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h1000;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            stall;
  logic            flush_valid;
  logic [XLEN-1:0] flush_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic [31:0]     perf_fetch_cnt;
  logic [31:0]     perf_flush_cnt;

  fetch_controller #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .flush_valid    (flush_valid),
    .flush_pc       (flush_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model
  logic        m_started, m_inflight, m_discard, m_valid;
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr, m_fetch, m_flush;
  logic        mem_pending;
  // values seen just before the last edge
  logic        exp_req, obs_req;
  logic [63:0] exp_addr, obs_addr;

  function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef FETCH_PERF_CNT_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  task automatic model_reset();
    m_started = 0; m_inflight = 0; m_discard = 0; m_valid = 0;
    m_pc = RESET_PC; m_ifpc = '0; m_instr = '0; m_fetch = '0; m_flush = '0;
    mem_pending = 0;
  endtask

  task automatic tick(input logic st, input logic fl, input logic [63:0] fpc,
                      input logic gn, input logic rv, input logic [31:0] rd);
    logic grant;
    stall = st; flush_valid = fl; flush_pc = fpc;
    imem_gnt = gn; imem_rvalid = rv; imem_rdata = rd;
    #1;
    exp_req  = m_started && !m_inflight && !fl && (!m_valid || !st);
    exp_addr = m_pc;
    obs_req  = imem_req;
    obs_addr = imem_addr;
    @(posedge clk);
    grant = exp_req && gn;
    if (fl) begin
      m_flush = m_flush + 1;
      m_valid = 0;
      m_pc    = {fpc[63:2], 2'b00};
      m_started = 1;
      if (m_inflight && !m_discard) begin
        m_inflight = !rv;
        m_discard  = !rv;
      end
    end else begin
      if (m_valid && !st) m_valid = 0;
      if (!m_started) m_started = 1;
      else if (!m_inflight) begin
        if (grant) m_inflight = 1;
      end else if (rv) begin
        m_inflight = 0;
        if (m_discard) m_discard = 0;
        else begin
          m_valid = 1; m_ifpc = m_pc; m_instr = rd;
          m_pc = m_pc + 64'd4;
          m_fetch = m_fetch + 1;
        end
      end
    end
    if (obs_req && gn) mem_pending = 1;
    else if (rv) mem_pending = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 0; stall = 0; flush_valid = 0; flush_pc = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    imem_gnt = 1; imem_rvalid = 1; #1;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== RESET_PC) $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_valid); else n_pass++;
    n_checks++; if (if_pc !== 64'd0 || if_instr !== 32'd0)
      $display("FAIL reset_entry: got pc %h instr %h want 0 0", if_pc, if_instr); else n_pass++;
    n_checks++; if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0)
      $display("FAIL reset_cnt: got %0d %0d want 0 0", perf_fetch_cnt, perf_flush_cnt); else n_pass++;
    imem_gnt = 0; imem_rvalid = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_sequential();
    tick(0, 0, '0, 1, 0, '0);
    n_checks++; if (obs_req !== 1'b0) $display("FAIL seq_idle_req: got %b want 0", obs_req); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, '0, 1, 0, '0);
      n_checks++; if (obs_req !== 1'b1 || obs_addr !== RESET_PC + 64'(4 * i))
        $display("FAIL seq_addr%0d: got req %b addr %h want 1 %h", i, obs_req, obs_addr, RESET_PC + 64'(4 * i)); else n_pass++;
      tick(0, 0, '0, 0, 1, 32'hA000_0000 + 32'(i));
      n_checks++; if (if_valid !== 1'b1 || if_pc !== RESET_PC + 64'(4 * i) || if_instr !== 32'hA000_0000 + 32'(i))
        $display("FAIL seq_load%0d: got v %b pc %h instr %h want 1 %h %h", i, if_valid, if_pc, if_instr,
                 RESET_PC + 64'(4 * i), 32'hA000_0000 + 32'(i)); else n_pass++;
    end
    n_checks++; if (perf_fetch_cnt !== cnt_exp(32'd3))
      $display("FAIL seq_fetch_cnt: got %0d want %0d", perf_fetch_cnt, cnt_exp(32'd3)); else n_pass++;
  endtask

  task automatic test_stall();
    // entry from the last sequential load is still valid
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, '0, 1, 0, '0);
      n_checks++; if (obs_req !== 1'b0) $display("FAIL stall_req%0d: got %b want 0", i, obs_req); else n_pass++;
      n_checks++; if (if_valid !== 1'b1 || if_pc !== RESET_PC + 64'd8 || if_instr !== 32'hA000_0002)
        $display("FAIL stall_hold%0d: got v %b pc %h instr %h want 1 %h a0000002", i, if_valid, if_pc, if_instr,
                 RESET_PC + 64'd8); else n_pass++;
    end
    tick(0, 0, '0, 1, 0, '0);
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== RESET_PC + 64'd12)
      $display("FAIL stall_resume: got req %b addr %h want 1 %h", obs_req, obs_addr, RESET_PC + 64'd12); else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL stall_consume: got %b want 0", if_valid); else n_pass++;
  endtask

  task automatic test_flush_wait();
    logic [31:0] fl0;
    fl0 = perf_flush_cnt;
    tick(0, 1, 64'h2003, 0, 0, '0);
    n_checks++; if (if_valid !== 1'b0 || imem_addr !== 64'h2000)
      $display("FAIL flushw_redirect: got v %b addr %h want 0 2000", if_valid, imem_addr); else n_pass++;
    tick(0, 0, '0, 1, 0, '0);
    n_checks++; if (obs_req !== 1'b0) $display("FAIL flushw_noreq: got %b want 0", obs_req); else n_pass++;
    tick(0, 0, '0, 1, 1, 32'hDEAD_BEEF);
    n_checks++; if (if_valid !== 1'b0) $display("FAIL flushw_discard: got %b want 0", if_valid); else n_pass++;
    tick(0, 0, '0, 1, 0, '0);
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 64'h2000)
      $display("FAIL flushw_req: got req %b addr %h want 1 2000", obs_req, obs_addr); else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL flushw_empty: got %b want 0", if_valid); else n_pass++;
    tick(0, 0, '0, 0, 1, 32'h1234_5678);
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 64'h2000 || if_instr !== 32'h1234_5678)
      $display("FAIL flushw_load: got v %b pc %h instr %h want 1 2000 12345678", if_valid, if_pc, if_instr); else n_pass++;
    n_checks++; if (perf_flush_cnt !== fl0 + cnt_exp(32'd1))
      $display("FAIL flushw_cnt: got %0d want %0d", perf_flush_cnt, fl0 + cnt_exp(32'd1)); else n_pass++;
  endtask

  task automatic test_flush_rvalid();
    logic [31:0] fl0;
    tick(0, 0, '0, 1, 0, '0);  // consumes the entry, request granted
    fl0 = perf_flush_cnt;
    tick(0, 1, 64'h3000, 0, 1, 32'hCAFE_F00D);
    n_checks++; if (if_valid !== 1'b0) $display("FAIL flushr_noload: got %b want 0", if_valid); else n_pass++;
    n_checks++; if (perf_flush_cnt !== fl0 + cnt_exp(32'd1))
      $display("FAIL flushr_cnt: got %0d want %0d", perf_flush_cnt, fl0 + cnt_exp(32'd1)); else n_pass++;
    tick(0, 0, '0, 1, 0, '0);
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 64'h3000)
      $display("FAIL flushr_req: got req %b addr %h want 1 3000", obs_req, obs_addr); else n_pass++;
    tick(0, 0, '0, 0, 1, 32'h0000_0013);
  endtask

  task automatic test_wrap();
    tick(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, '0);
    tick(0, 0, '0, 1, 0, '0);
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
      $display("FAIL wrap_req: got req %b addr %h want 1 fffffffffffffffc", obs_req, obs_addr); else n_pass++;
    tick(0, 0, '0, 0, 1, 32'h5555_AAAA);
    n_checks++; if (if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || imem_addr !== 64'd0)
      $display("FAIL wrap_pc: got if_pc %h addr %h want fffffffffffffffc 0", if_pc, imem_addr); else n_pass++;
    tick(0, 0, '0, 1, 0, '0);
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 64'd0)
      $display("FAIL wrap_next: got req %b addr %h want 1 0", obs_req, obs_addr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    // previous task left the controller waiting on a response
    #2 reset_n = 0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || imem_addr !== RESET_PC || if_valid !== 1'b0)
      $display("FAIL rstmid_async: got req %b addr %h v %b want 0 %h 0", imem_req, imem_addr, if_valid, RESET_PC); else n_pass++;
    model_reset();
    @(negedge clk);
    reset_n = 1;
    tick(0, 0, '0, 0, 1, 32'hBAD0_BAD0);
    n_checks++; if (if_valid !== 1'b0 || imem_addr !== RESET_PC)
      $display("FAIL rstmid_late: got v %b addr %h want 0 %h", if_valid, imem_addr, RESET_PC); else n_pass++;
    tick(0, 0, '0, 0, 1, 32'hBAD1_BAD1);
    n_checks++; if (if_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== RESET_PC)
      $display("FAIL rstmid_req: got v %b req %b addr %h want 0 1 %h", if_valid, obs_req, obs_addr, RESET_PC); else n_pass++;
    n_checks++; if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0)
      $display("FAIL rstmid_cnt: got %0d %0d want 0 0", perf_fetch_cnt, perf_flush_cnt); else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    logic st, fl, gn, rv;
    logic [63:0] fpc;
    errs = 0;
    for (int c = 0; c < 3000 && errs < 10; c++) begin
      st  = ($urandom % 4) == 0;
      gn  = ($urandom % 2) == 0;
      rv  = mem_pending ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
      fl  = ($urandom % 16) == 0;
      if (m_discard && rv) fl = 0;
      fpc = (($urandom % 8) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16)
                                  : {$urandom, $urandom};
      tick(st, fl, fpc, gn, rv, $urandom);
      n_checks++; if (obs_req !== exp_req || obs_addr !== exp_addr) begin
        errs++; $display("FAIL rnd_req c%0d: got req %b addr %h want %b %h", c, obs_req, obs_addr, exp_req, exp_addr);
      end else n_pass++;
      n_checks++; if (if_valid !== m_valid || (m_valid && (if_pc !== m_ifpc || if_instr !== m_instr))) begin
        errs++; $display("FAIL rnd_entry c%0d: got v %b pc %h instr %h want %b %h %h", c, if_valid, if_pc, if_instr,
                         m_valid, m_ifpc, m_instr);
      end else n_pass++;
      n_checks++; if (perf_fetch_cnt !== cnt_exp(m_fetch) || perf_flush_cnt !== cnt_exp(m_flush)) begin
        errs++; $display("FAIL rnd_cnt c%0d: got %0d %0d want %0d %0d", c, perf_fetch_cnt, perf_flush_cnt,
                         cnt_exp(m_fetch), cnt_exp(m_flush));
      end else n_pass++;
    end
  endtask

  initial begin
    reset_n = 0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_flush_wait();
    test_flush_rvalid();
    test_wrap();
    tick(0, 0, '0, 1, 0, '0);  // leave a request outstanding
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
